// File: rtl/param_median_wake.sv
// param_median_wake
//
// Scans a binary image held in an external pixel memory as non-overlapping
// WIN x WIN tiles. For each tile it reads every pixel, takes a majority vote
// (a tie votes 0), and writes that median bit to a tile-result memory. It
// counts the tiles whose median is 1. At the end of the frame it compares
// that count against a threshold latched at start and raises a sticky wake
// request when the count is strictly greater.
//
// Optional feature, macro PARAM_MEDIAN_WAKE_PERSIST_EN:
//   defined   - wakeUp needs PERSIST consecutive over-threshold frames
//   undefined - any single over-threshold frame sets wakeUp
//
// Ports
//   clk                   sole clock, rising edge
//   reset                 asynchronous, active-low reset
//   start                 frame-scan request, honoured only while idle
//   threshold             wake threshold, latched on an accepted start
//   wakeClear             clears wakeUp and the persistence count
//   dataIn                pixel read data, valid the cycle after readEn
//   readEn                pixel read strobe
//   xAddressOut/yAddressOut                    pixel read address (col, row)
//   writeMedianMem        one-cycle tile-result write strobe
//   xAddressOutMedianMem/yAddressOutMedianMem  tile coordinates of the write
//   writeMedianData       tile median bit
//   activeWindows         tiles with median 1 in the current/last frame
//   busy                  high whenever a scan is in progress
//   fullImageDone         one-cycle end-of-frame pulse
//   wakeUp                sticky wake request
module param_median_wake #(
    parameter int IMG_W   = 160,
    parameter int IMG_H   = 120,
    parameter int WIN     = 2,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 13,
    parameter int PERSIST = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  threshold,
    input  logic              wakeClear,
    input  logic              dataIn,
    output logic              readEn,
    output logic [ADDR_W-1:0] xAddressOut,
    output logic [ADDR_W-1:0] yAddressOut,
    output logic              writeMedianMem,
    output logic [ADDR_W-1:0] xAddressOutMedianMem,
    output logic [ADDR_W-1:0] yAddressOutMedianMem,
    output logic              writeMedianData,
    output logic [CNT_W-1:0]  activeWindows,
    output logic              busy,
    output logic              fullImageDone,
    output logic              wakeUp
);

    localparam int TILES_X = IMG_W / WIN;
    localparam int TILES_Y = IMG_H / WIN;
    localparam int PIX     = WIN * WIN;
    localparam int ONES_W  = $clog2(PIX + 1);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   off_x;
    logic [ADDR_W-1:0]   off_y;
    logic [ADDR_W-1:0]   tile_x;
    logic [ADDR_W-1:0]   tile_y;
    logic [ONES_W-1:0]   ones;
    logic                rd_pending;
    logic [CNT_W-1:0]    thr_q;
    logic [CNT_W-1:0]    active_q;
    logic                wake_q;
    logic                last_pix;
    logic                last_tile;
    logic                median;
    logic                hit;

    assign last_pix  = (off_x == ADDR_W'(WIN - 1)) && (off_y == ADDR_W'(WIN - 1));
    assign last_tile = (tile_x == ADDR_W'(TILES_X - 1)) && (tile_y == ADDR_W'(TILES_Y - 1));
    // Strict majority: exactly half the pixels set is a tie and votes 0.
    assign median    = (2 * int'(ones)) > PIX;
    assign hit       = active_q > thr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = READ;
            READ:    if (last_pix) state_next = DRAIN;
            DRAIN:   state_next = WRITE;
            WRITE:   state_next = last_tile ? DONE : READ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        readEn               = (state == READ);
        writeMedianMem       = (state == WRITE);
        busy                 = (state != IDLE);
        fullImageDone        = (state == DONE);
        xAddressOut          = '0;
        yAddressOut          = '0;
        xAddressOutMedianMem = '0;
        yAddressOutMedianMem = '0;
        writeMedianData      = 1'b0;
        if (readEn) begin
            xAddressOut = tile_x * ADDR_W'(WIN) + off_x;
            yAddressOut = tile_y * ADDR_W'(WIN) + off_y;
        end
        if (writeMedianMem) begin
            xAddressOutMedianMem = tile_x;
            yAddressOutMedianMem = tile_y;
            writeMedianData      = median;
        end
        activeWindows = active_q;
        wakeUp        = wake_q;
    end

    // Datapath. rd_pending marks the cycle in which the pixel requested one
    // cycle earlier is on dataIn; the first READ cycle of a tile has nothing
    // to capture and DRAIN captures the tile's final pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            off_x      <= '0;
            off_y      <= '0;
            tile_x     <= '0;
            tile_y     <= '0;
            ones       <= '0;
            rd_pending <= 1'b0;
            thr_q      <= '0;
            active_q   <= '0;
        end else begin
            rd_pending <= (state == READ);
            case (state)
                IDLE: begin
                    if (start) begin
                        thr_q    <= threshold;
                        active_q <= '0;
                        tile_x   <= '0;
                        tile_y   <= '0;
                        off_x    <= '0;
                        off_y    <= '0;
                        ones     <= '0;
                    end
                end
                READ: begin
                    if (rd_pending && dataIn) ones <= ones + ONES_W'(1);
                    if (off_x == ADDR_W'(WIN - 1)) begin
                        off_x <= '0;
                        off_y <= (off_y == ADDR_W'(WIN - 1)) ? '0 : off_y + ADDR_W'(1);
                    end else begin
                        off_x <= off_x + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (rd_pending && dataIn) ones <= ones + ONES_W'(1);
                end
                WRITE: begin
                    if (median) active_q <= active_q + CNT_W'(1);
                    ones <= '0;
                    if (!last_tile) begin
                        if (tile_x == ADDR_W'(TILES_X - 1)) begin
                            tile_x <= '0;
                            tile_y <= tile_y + ADDR_W'(1);
                        end else begin
                            tile_x <= tile_x + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PARAM_MEDIAN_WAKE_PERSIST_EN
    localparam int HITS_W = $clog2(PERSIST + 1);

    logic [HITS_W-1:0] hits;

    // Saturating run-length of consecutive over-threshold frames. A clear
    // request outranks a simultaneous end-of-frame evaluation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hits   <= '0;
            wake_q <= 1'b0;
        end else if (wakeClear) begin
            hits   <= '0;
            wake_q <= 1'b0;
        end else if (state == DONE) begin
            if (hit) begin
                if (int'(hits) < PERSIST) hits <= hits + HITS_W'(1);
                if (int'(hits) + 1 >= PERSIST) wake_q <= 1'b1;
            end else begin
                hits <= '0;
            end
        end
    end
`else
    // PERSIST only shapes the persistence counter, which this build omits.
    logic unused_persist;
    assign unused_persist = (PERSIST > 0);

    // A single over-threshold frame sets the sticky wake request; a clear
    // request outranks a simultaneous end-of-frame evaluation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wake_q <= 1'b0;
        end else if (wakeClear) begin
            wake_q <= 1'b0;
        end else if (state == DONE && hit) begin
            wake_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_param_median_wake.sv
// Self-checking bench for param_median_wake on an 8x4 image with 2x2 tiles.
// A pixel-memory responder answers readEn one cycle later from the bench's
// image array; the expected outputs of each frame cycle are derived from the
// tile index and phase, and the tile medians from counting the image pixels.
module tb_param_median_wake;

    localparam int IMG_W   = 8;
    localparam int IMG_H   = 4;
    localparam int WIN     = 2;
    localparam int ADDR_W  = 8;
    localparam int CNT_W   = 13;
    localparam int PERSIST = 2;
    localparam int TX      = IMG_W / WIN;
    localparam int TY      = IMG_H / WIN;
    localparam int NT      = TX * TY;
    localparam int TC      = WIN * WIN + 2;
    localparam int FRAME   = NT * TC + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  threshold = '0;
    logic              wakeClear = 1'b0;
    logic              dataIn = 1'b0;
    logic              readEn;
    logic [ADDR_W-1:0] xAddressOut;
    logic [ADDR_W-1:0] yAddressOut;
    logic              writeMedianMem;
    logic [ADDR_W-1:0] xAddressOutMedianMem;
    logic [ADDR_W-1:0] yAddressOutMedianMem;
    logic              writeMedianData;
    logic [CNT_W-1:0]  activeWindows;
    logic              busy;
    logic              fullImageDone;
    logic              wakeUp;

    int vectors = 0;
    int miscompares = 0;
    bit img [IMG_H*IMG_W];
    bit model_wake = 1'b0;
    int model_hits = 0;
    bit rsp_valid = 1'b0;
    bit rsp_bit = 1'b0;

    param_median_wake #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN),
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .PERSIST(PERSIST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .threshold(threshold),
        .wakeClear(wakeClear),
        .dataIn(dataIn),
        .readEn(readEn),
        .xAddressOut(xAddressOut),
        .yAddressOut(yAddressOut),
        .writeMedianMem(writeMedianMem),
        .xAddressOutMedianMem(xAddressOutMedianMem),
        .yAddressOutMedianMem(yAddressOutMedianMem),
        .writeMedianData(writeMedianData),
        .activeWindows(activeWindows),
        .busy(busy),
        .fullImageDone(fullImageDone),
        .wakeUp(wakeUp)
    );

    always #5 clk = ~clk;

    // Pixel memory: remember the request seen in this cycle and present the
    // answer just after the next rising edge; otherwise drive noise.
    always @(negedge clk) begin
        rsp_valid = readEn && (int'(xAddressOut) < IMG_W) && (int'(yAddressOut) < IMG_H);
        rsp_bit   = rsp_valid ? img[int'(yAddressOut) * IMG_W + int'(xAddressOut)] : 1'b0;
    end

    always @(posedge clk) begin
        #1;
        dataIn = rsp_valid ? rsp_bit : 1'($urandom);
    end

    function automatic int tile_ones(input int t);
        int n;
        n = 0;
        for (int dy = 0; dy < WIN; dy++)
            for (int dx = 0; dx < WIN; dx++)
                n += int'(img[((t / TX) * WIN + dy) * IMG_W + (t % TX) * WIN + dx]);
        return n;
    endfunction

    function automatic bit tile_median(input int t);
        return (2 * tile_ones(t)) > (WIN * WIN);
    endfunction

    // Tiles with median 1 among the first n tiles of the scan.
    function automatic int medians_before(input int n);
        int m;
        m = 0;
        for (int t = 0; t < n; t++) m += int'(tile_median(t));
        return m;
    endfunction

    function automatic logic [63:0] obs_bus();
        return {27'd0, readEn, xAddressOut, yAddressOut, writeMedianMem,
                xAddressOutMedianMem, yAddressOutMedianMem, writeMedianData,
                fullImageDone, busy};
    endfunction

    // Expected strobe/address bundle in cycle c (1..FRAME) after the accepting edge.
    function automatic logic [63:0] exp_bus(input int c);
        logic       rd, wm, wd, fd;
        logic [7:0] xa, ya, xm, ym;
        int         t, ph;
        rd = 0; wm = 0; wd = 0; fd = 0;
        xa = 0; ya = 0; xm = 0; ym = 0;
        t  = (c - 1) / TC;
        ph = (c - 1) % TC;
        if (c == FRAME) begin
            fd = 1;
        end else if (ph < WIN * WIN) begin
            rd = 1;
            xa = 8'((t % TX) * WIN + ph % WIN);
            ya = 8'((t / TX) * WIN + ph / WIN);
        end else if (ph == WIN * WIN + 1) begin
            wm = 1;
            xm = 8'(t % TX);
            ym = 8'(t / TX);
            wd = tile_median(t);
        end
        return {27'd0, rd, xa, ya, wm, xm, ym, wd, fd, 1'b1};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_bus"}, obs_bus(), 64'd0);
        checkOutput({tag, "_wake"}, 64'(wakeUp), 64'(model_wake));
    endtask

    task automatic clearWake();
        wakeClear = 1'b1;
        @(negedge clk);
        wakeClear = 1'b0;
        model_wake = 1'b0;
        model_hits = 0;
        checkOutput("wake_clear", 64'(wakeUp), 64'd0);
    endtask

    task automatic set_tile(input int t, input int n);
        int r, k;
        r = int'($urandom_range(0, WIN * WIN - 1));
        for (int p = 0; p < WIN * WIN; p++) begin
            k = (r + p) % (WIN * WIN);
            img[((t / TX) * WIN + k / WIN) * IMG_W + (t % TX) * WIN + k % WIN] = (p < n);
        end
    endtask

    // One frame starting at a negedge while idle. start_at re-asserts start
    // mid-scan, clear_at pulses wakeClear in that cycle, reset_at pulls reset
    // low in that cycle and abandons the frame (0 disables each).
    task automatic applyStimulus(input logic [CNT_W-1:0] thr, input int start_at,
                                 input int clear_at, input int reset_at);
        int  total;
        bit  frame_hit;
        total = medians_before(NT);
        start = 1'b1;
        threshold = thr;
        @(posedge clk);
        #1;
        start = 1'b0;
        threshold = CNT_W'($urandom);
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            if (c == reset_at) begin
                reset = 1'b0;
                #1;
                model_wake = 1'b0;
                model_hits = 0;
                checkOutput("rst_bus", obs_bus(), 64'd0);
                checkOutput("rst_active", 64'(activeWindows), 64'd0);
                checkOutput("rst_wake", 64'(wakeUp), 64'd0);
                @(negedge clk);
                reset = 1'b1;
                for (int i = 0; i < FRAME + 4; i++) begin
                    @(negedge clk);
                    checkOutput("post_rst_idle", obs_bus(), 64'd0);
                end
                return;
            end
            checkOutput($sformatf("bus_c%0d", c), obs_bus(), exp_bus(c));
            checkOutput($sformatf("active_c%0d", c), 64'(activeWindows),
                        64'(medians_before((c - 1) / TC)));
            checkOutput($sformatf("wake_c%0d", c), 64'(wakeUp), 64'(model_wake));
            start = (c == start_at);
            wakeClear = (c == clear_at);
            if (c == FRAME) begin
                frame_hit = total > int'(thr);
                if (wakeClear) begin
                    model_wake = 1'b0;
                    model_hits = 0;
                end else begin
`ifdef PARAM_MEDIAN_WAKE_PERSIST_EN
                    if (frame_hit) begin
                        if (model_hits < PERSIST) model_hits++;
                        if (model_hits >= PERSIST) model_wake = 1'b1;
                    end else begin
                        model_hits = 0;
                    end
`else
                    if (frame_hit) model_wake = 1'b1;
`endif
                end
            end else if (wakeClear) begin
                model_wake = 1'b0;
                model_hits = 0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        wakeClear = 1'b0;
        checkOutput("end_bus", obs_bus(), 64'd0);
        checkOutput("end_active", 64'(activeWindows), 64'(total));
        checkOutput("end_wake", 64'(wakeUp), 64'(model_wake));
    endtask

    initial begin
        int r;
        #2;
        reset = 1'b0;
        #1;
        checkIdle("reset_async");
        checkOutput("reset_active", 64'(activeWindows), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkIdle("after_release");

        $display("[TB] all-ones image, threshold 7");
        for (int i = 0; i < IMG_H * IMG_W; i++) img[i] = 1'b1;
        applyStimulus(CNT_W'(7), 0, 0, 0);
        clearWake();

        $display("[TB] tie tile then majority tile");
        for (int i = 0; i < IMG_H * IMG_W; i++) img[i] = 1'($urandom);
        set_tile(0, 2);
        set_tile(1, 3);
        applyStimulus(CNT_W'(NT), 0, 0, 0);

        $display("[TB] five active tiles, threshold equal then below");
        clearWake();
        r = int'($urandom_range(0, NT - 1));
        for (int t = 0; t < NT; t++) begin
            if (((t - r + NT) % NT) < 5) set_tile(t, int'($urandom_range(3, 4)));
            else set_tile(t, int'($urandom_range(0, 2)));
        end
        applyStimulus(CNT_W'(5), 0, 0, 0);
        applyStimulus(CNT_W'(4), 0, 0, 0);

        $display("[TB] random frames with mid-scan start and wakeClear");
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < IMG_H * IMG_W; i++) img[i] = 1'($urandom);
            applyStimulus(CNT_W'($urandom_range(0, NT)), 10,
                          ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, FRAME - 1)) : 0, 0);
        end

        $display("[TB] wakeClear coincident with a hitting end of frame");
        clearWake();
        for (int i = 0; i < IMG_H * IMG_W; i++) img[i] = 1'b1;
        applyStimulus(CNT_W'(0), 0, FRAME, 0);

        $display("[TB] reset in cycle 20, then a full frame");
        applyStimulus(CNT_W'(0), 0, 0, 20);
        for (int i = 0; i < IMG_H * IMG_W; i++) img[i] = 1'($urandom);
        applyStimulus(CNT_W'($urandom_range(0, 3)), 0, 0, 0);

`ifdef PARAM_MEDIAN_WAKE_PERSIST_EN
        $display("[TB] persistence: hit, miss, hit, hit");
        clearWake();
        r = int'($urandom_range(0, NT - 1));
        for (int t = 0; t < NT; t++) begin
            if (((t - r + NT) % NT) < 5) set_tile(t, 4);
            else set_tile(t, 0);
        end
        applyStimulus(CNT_W'(4), 0, 0, 0);
        applyStimulus(CNT_W'(5), 0, 0, 0);
        applyStimulus(CNT_W'(4), 0, 0, 0);
        applyStimulus(CNT_W'(4), 0, 0, 0);
        clearWake();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/param_median_wake.md
PARAM_MEDIAN_WAKE -- requirements
Module: param_median_wake

Interface
REQ-001 Parameters, one per line: name, default, meaning; all SHALL be overridable at instantiation.
- IMG_W, 160, image width in pixels (multiple of WIN).
- IMG_H, 120, image height in pixels (multiple of WIN).
- WIN, 2, tile edge in pixels (non-overlapping WIN x WIN tiles).
- ADDR_W, 8, pixel/tile address width.
- CNT_W, 13, active-window counter and threshold width; SHALL hold (IMG_W/WIN)*(IMG_H/WIN).
- PERSIST, 2, consecutive over-threshold frames needed for wake (used only with PERSIST_EN).
REQ-002 Ports, one per line: name, direction, width, meaning; one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  frame-scan request, honoured only in IDLE.
- threshold  in  CNT_W  wake threshold, latched on accepted start.
- wakeClear  in  1  clears wakeUp and the persistence count.
- dataIn  in  1  pixel read data, valid the cycle after readEn.
- readEn  out  1  pixel read strobe.
- xAddressOut, yAddressOut  out  ADDR_W  pixel read address (column, row).
- writeMedianMem  out  1  one-cycle tile-result write strobe.
- xAddressOutMedianMem, yAddressOutMedianMem  out  ADDR_W  tile coordinates; 0 when writeMedianMem=0.
- writeMedianData  out  1  tile median bit; 0 when writeMedianMem=0.
- activeWindows  out  CNT_W  count of tiles with median 1 in the current/last frame.
- busy  out  1  high in every state except IDLE.
- fullImageDone  out  1  one-cycle end-of-frame pulse.
- wakeUp  out  1  sticky wake request.

Function
REQ-003 States SHALL be IDLE, READ, DRAIN, WRITE, DONE.
REQ-004 IDLE with start=1: latch threshold, clear activeWindows, go to READ at tile (0,0); start outside IDLE SHALL be ignored.
REQ-005 READ: readEn=1 for WIN*WIN consecutive cycles, pixels row-major within the tile; address = tile origin + offset; then DRAIN.
REQ-006 Each dataIn SHALL be sampled one cycle after its readEn; the DRAIN cycle captures the last pixel.
REQ-007 WRITE: one cycle with writeMedianMem=1, tile coordinates, writeMedianData = (2*ones > WIN*WIN); a tie SHALL give 0.
REQ-008 activeWindows SHALL increment on the same edge whenever writeMedianData=1; no wrap possible by REQ-001 sizing.
REQ-009 Tiles SHALL be scanned row-major; after the last tile go to DONE, otherwise go to READ for the next tile.
REQ-010 Per tile WIN*WIN+2 cycles; DONE occurs (IMG_W/WIN)*(IMG_H/WIN)*(WIN*WIN+2)+1 cycles after the accepting edge.
REQ-011 DONE: fullImageDone=1 for one cycle, wake evaluation, return to IDLE; activeWindows SHALL hold until the next accepted start.
REQ-012 "Hit" SHALL mean activeWindows > latched threshold (strict); equality is not a hit.
REQ-013 wakeUp SHALL update on the edge leaving DONE, stay 1 until wakeClear or reset, and be visible the cycle after fullImageDone.
REQ-014 wakeClear SHALL take effect the next edge; if coincident with a wake set, clear SHALL win.
REQ-015 wakeClear SHALL NOT disturb an ongoing scan.

Reset
REQ-016 reset=0 SHALL immediately force IDLE and drive every output to 0, clearing counters, latched threshold and the persistence count.
REQ-017 A reset mid-frame SHALL abandon the frame with no fullImageDone; the first start after release SHALL scan from tile (0,0).

Configuration
REQ-018 Macro PARAM_MEDIAN_WAKE_PERSIST_EN.
- Defined: a saturating hit counter (width fits PERSIST) increments on each DONE hit and clears on each miss; wakeUp sets when it reaches PERSIST.
- Undefined: wakeUp sets on any single DONE hit; no counter is built.

Verification (IMG_W=8, IMG_H=4, WIN=2, 8 tiles, frame 49 cycles)
REQ-019 All-ones image, threshold=7, start -> 8 writes with data=1; activeWindows=8; fullImageDone at cycle 49; wakeUp=1 at cycle 50 (macro undefined).
REQ-020 Tile (0,0) with 2 ones, tile (1,0) with 3 ones -> data 0 then 1 at yAddressOutMedianMem=0, xAddressOutMedianMem 0 then 1.
REQ-021 Image giving activeWindows=5, threshold=5 -> no wake; rerun with threshold=4 -> wakeUp=1.
REQ-022 reset pulsed low at cycle 20 -> all outputs 0 at once, no fullImageDone; next start completes a full 49-cycle frame.
REQ-023 Macro defined, PERSIST=2, frames hit/miss/hit -> wakeUp=0; then a second consecutive hit -> wakeUp=1; wakeClear -> 0 the next cycle.
REQ-024 start asserted at cycle 10 of a frame -> ignored, frame timing unchanged; wakeClear coincident with DONE hit -> wakeUp stays 0.
